ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction-fetch front end of the Fibonacci core. It consumes the address stream produced by the program counter and issues read requests to instruction memory.
- Memory has variable latency. The block pairs each returned word with the PC that requested it and buffers the pairs in order for the decoder.
- Provides a back-pressure path to hold the PC, plus a flush for taken branches so wrong-path words are discarded.

Parameters:
- DEPTH, 4, output FIFO entries; also the maximum number of requests in flight. Power of two, at least 2.
- XLEN, 32, address and instruction width.

Ports:
- clk  input  1  system clock
- arst_n  input  1  asynchronous active-low reset
- pc_in  input  XLEN  fetch address from the PC
- pc_valid  input  1  pc_in valid
- pc_ready  output  1  fetch accepted this cycle; the PC advances only on pc_valid&pc_ready
- flush  input  1  taken branch/redirect; discard everything older
- imem_req_valid  output  1  memory read request
- imem_req_ready  input  1  memory accepts the request
- imem_addr  output  XLEN  word-aligned read address
- imem_rsp_valid  input  1  read data returned (in order, no back-pressure)
- imem_rsp_data  input  XLEN  instruction word
- instr_valid  output  1  decoder output valid
- instr_ready  input  1  decoder accepts
- instr_data  output  XLEN  instruction word
- instr_pc  output  XLEN  PC of instr_data
- misalign_err  output  1  sticky: a fetch with pc_in[1:0]!=0 was issued

Behaviour:
- Reset (arst_n=0, asynchronous) clears:
  - all outputs to 0;
  - FIFO pointers and count, the live-outstanding counter `live`, the discard counter `disc`, the tag queue, and misalign_err.
- Credit:
  - credit_ok = (live + fifo_count < DEPTH) && (live + disc < DEPTH).
  - Because of this credit, a response can never find the FIFO full.
- Request path (combinational):
  - imem_req_valid = pc_valid & credit_ok & ~flush.
  - imem_addr = {pc_in[XLEN-1:2], 2'b00}.
  - pc_ready = imem_req_valid & imem_req_ready.
  - fire = pc_valid & pc_ready.
- On fire:
  - pc_in is pushed into the in-order tag queue (DEPTH entries) and `live` increments.
  - If pc_in[1:0]!=0, misalign_err is set and stays set until reset.
- On imem_rsp_valid:
  - If disc>0: the word is dropped and disc decrements.
  - Else: pop the tag, push {tag, imem_rsp_data} into the output FIFO, and decrement `live`.
  - fire and a response in the same cycle: net `live` is unchanged.
- Output:
  - instr_valid = fifo_count!=0; instr_data/instr_pc come from the FIFO head.
  - The head pops on instr_valid&instr_ready.
  - Latency: response in cycle N gives instr_valid in cycle N+1 (registered FIFO).
  - Push and pop in the same cycle leave the count unchanged.
  - instr_data/instr_pc hold stable while instr_valid&~instr_ready.
- flush (one cycle, highest priority):
  - No request is issued that cycle.
  - The output FIFO and tag queue are cleared.
  - A response arriving in the flush cycle is dropped.
  - disc <= disc + live, minus 1 if a response arrived this cycle and was counted in live (saturating at 0). live <= 0.
  - instr_valid is 0 in the next cycle.
- FIFO pointers wrap modulo DEPTH.
- No combinational path from imem_rsp_* to instr_*.
- All counters are sized $clog2(DEPTH)+1.
- Reset asserted mid-operation discards everything. After reset, responses from requests issued before the reset are the memory's responsibility: memory is reset with the same arst_n.

Test Plan:
1. Reset, then PCs 0x0,0x4,0x8,0xC on consecutive cycles; memory with 1-cycle latency returns 0xA0..0xA3; instr_ready=1 -> instr_pc/instr_data = (0x0,0xA0)..(0xC,0xA3), each 1 cycle after its response, in order.
2. instr_ready=0 with continuous pc_valid -> exactly 4 requests issued, then pc_ready=0; raising instr_ready for one cycle -> exactly one new request allowed; outputs stable while stalled.
3. Two requests in flight (0x10,0x14), flush pulse, then PC 0x40 -> both late responses dropped; first instr_valid carries instr_pc=0x40.
4. Flush in the same cycle as a response and a pc_valid -> response dropped, no request that cycle, instr_valid=0 next cycle, disc correct.
5. pc_in=0x6 -> imem_addr=0x4, misalign_err=1 and stays 1 across further fetches until reset.
6. Assert arst_n=0 with 3 FIFO entries and 1 in flight -> instr_valid, imem_req_valid, misalign_err go 0 immediately; the next fetch after reset behaves as in scenario 1.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: PC handshake, instruction-memory request/response
// and the decoder-side instruction stream.
interface ifetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_in;
  logic            pc_valid;
  logic            pc_ready;
  logic            flush;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            misalign_err;

  // Environment side: PC, memory and decoder.
  modport master (
    output pc_in, pc_valid, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  pc_ready, imem_req_valid, imem_addr, instr_valid, instr_data, instr_pc, misalign_err
  );

  // Fetch unit side.
  modport slave (
    input  pc_in, pc_valid, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output pc_ready, imem_req_valid, imem_addr, instr_valid, instr_data, instr_pc, misalign_err
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: issues PC-driven reads to a variable-latency
// in-order memory, tags returning words with their PC and queues the pairs
// for the decoder. Credits bound requests in flight so a response always
// finds room; a flush turns outstanding requests into words to discard.
module ifetch_unit #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic          clk,
  input logic          arst_n,
  ifetch_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          fifo_mem [DEPTH];
  logic [XLEN-1:0] tag_mem  [DEPTH];
  logic [AW-1:0]   f_wr, f_rd, t_wr, t_rd;
  logic [CW-1:0]   fifo_count, live, disc, disc_flush;
  logic [CW:0]     disc_sum;
  logic            credit_ok, req_valid, pc_ready, fire, rsp_take, rsp_drop, pop, misalign_err;

  // Request handshake, response steering and flush bookkeeping.
  always_comb begin
    credit_ok = (({1'b0, live} + {1'b0, fifo_count}) < DEPTH_W) &&
                (({1'b0, live} + {1'b0, disc}) < DEPTH_W);
    // Gating with arst_n keeps the request outputs at 0 while reset is held.
    req_valid = arst_n & bus.pc_valid & credit_ok & ~bus.flush;
    pc_ready  = req_valid & bus.imem_req_ready;
    fire      = bus.pc_valid & pc_ready;
    rsp_take  = bus.imem_rsp_valid & ~bus.flush & (disc == '0);
    rsp_drop  = bus.imem_rsp_valid & ~bus.flush & (disc != '0);
    pop       = (fifo_count != '0) & bus.instr_ready;
    // A response in the flush cycle retires one outstanding request,
    // whether it was live or already marked for discard.
    disc_sum  = {1'b0, disc} + {1'b0, live};
    if (bus.imem_rsp_valid && disc_sum != '0)
      disc_sum = disc_sum - (CW+1)'(1);
    disc_flush = disc_sum[CW-1:0];

    bus.imem_req_valid = req_valid;
    bus.pc_ready       = pc_ready;
    bus.imem_addr      = arst_n ? {bus.pc_in[XLEN-1:2], 2'b00} : '0;
    bus.instr_valid    = (fifo_count != '0);
    bus.instr_pc       = fifo_mem[f_rd].pc;
    bus.instr_data     = fifo_mem[f_rd].data;
    bus.misalign_err   = misalign_err;
  end

  // Pointers and counters; flush empties both queues and converts live to discard.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      f_wr <= '0; f_rd <= '0; t_wr <= '0; t_rd <= '0;
      fifo_count <= '0; live <= '0; disc <= '0;
    end else if (bus.flush) begin
      f_wr <= '0; f_rd <= '0; t_wr <= '0; t_rd <= '0;
      fifo_count <= '0; live <= '0;
      disc <= disc_flush;
    end else begin
      if (fire)     t_wr <= t_wr + 1'b1;
      if (rsp_take) begin
        t_rd <= t_rd + 1'b1;
        f_wr <= f_wr + 1'b1;
      end
      if (pop)      f_rd <= f_rd + 1'b1;
      live       <= live + CW'(fire) - CW'(rsp_take);
      disc       <= disc - CW'(rsp_drop);
      fifo_count <= fifo_count + CW'(rsp_take) - CW'(pop);
    end
  end

  // Tag queue and output FIFO storage; cleared on reset so outputs read 0.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem[i]  <= '0;
        fifo_mem[i] <= '0;
      end
    end else begin
      if (fire)     tag_mem[t_wr]  <= bus.pc_in;
      if (rsp_take) fifo_mem[f_wr] <= '{pc: tag_mem[t_rd], data: bus.imem_rsp_data};
    end
  end

  // Sticky flag for any issued fetch from a non-word-aligned PC.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                            misalign_err <= 1'b0;
    else if (fire && bus.pc_in[1:0] != 2'b00) misalign_err <= 1'b1;
  end
endmodule
